// File: rtl/sc_positionshifter_jug2.sv
// Player-2 one-hot lane position with saturating steps and auto-repeat.
// Ports: clock, sync high reset, low-active left/right/load, load bus,
// position bus, low-active side flag, move pulse.
module sc_positionshifter_jug2 #(
  parameter int DATAWIDTH = 8,
  parameter int LANEWIDTH = 4,
  parameter logic [DATAWIDTH-1:0] INIT_POS = 8'b00000100,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic                 SC_JUG2_CLOCK_50,
  input  logic                 SC_JUG2_RESET_InHigh,
  input  logic                 SC_JUG2_left_InLow,
  input  logic                 SC_JUG2_right_InLow,
  input  logic                 SC_JUG2_load_InLow,
  input  logic [DATAWIDTH-1:0] SC_JUG2_data_InBUS,
  output logic [DATAWIDTH-1:0] SC_JUG2_data_OutBUS,
  output logic                 SC_JUG2_side_OutLow,
  output logic                 SC_JUG2_move_Out
);

  localparam int CW = (REPEAT_CYCLES > 2) ?
    $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(REPEAT_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [DATAWIDTH-1:0] ONE =
    DATAWIDTH'(1);
  localparam logic [DATAWIDTH-1:0] EDGE_HI =
    ONE << (LANEWIDTH - 1);
  localparam logic [DATAWIDTH-1:0] LANE_MASK =
    ~({DATAWIDTH{1'b1}} << LANEWIDTH);
  localparam logic INIT_SIDE =
    !((INIT_POS == ONE) || (INIT_POS == EDGE_HI));

  logic [DATAWIDTH-1:0] pos_q, pos_d;
  logic                 side_q, side_d;
  logic                 move_q, move_d;
  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 dir_q, dir_d;

  logic req_l, req_r, req;
  logic load_ok;
  logic [DATAWIDTH-1:0] step_pos;

  assign req_l = !SC_JUG2_left_InLow && SC_JUG2_right_InLow;
  assign req_r = !SC_JUG2_right_InLow && SC_JUG2_left_InLow;
  assign req   = req_l || req_r;

  assign load_ok =
    ((SC_JUG2_data_InBUS & ~LANE_MASK) == '0) &&
    $onehot(SC_JUG2_data_InBUS);

  // Saturating step; direction taken from the live request.
  always_comb begin
    step_pos = pos_q;
    if (req_l) begin
      if (pos_q != EDGE_HI) step_pos = pos_q << 1;
    end else if (req_r) begin
      if (pos_q != ONE) step_pos = pos_q >> 1;
    end
  end

  always_comb begin
    pos_d   = pos_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (!SC_JUG2_load_InLow) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (load_ok) pos_d = SC_JUG2_data_InBUS;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            pos_d   = step_pos;
            state_d = WAIT;
            cnt_d   = '0;
            dir_d   = req_l;
          end
        end
        default: begin
          // Any change of request ends the repeat run.
          if (req && (req_l == dir_q)) begin
            if (cnt_q == CNT_MAX) begin
              pos_d = step_pos;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      endcase
    end
    move_d = (pos_d != pos_q);
    side_d = !((pos_d == ONE) || (pos_d == EDGE_HI));
  end

  always_ff @(posedge SC_JUG2_CLOCK_50) begin
    if (SC_JUG2_RESET_InHigh) begin
      pos_q   <= INIT_POS;
      side_q  <= INIT_SIDE;
      move_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      side_q  <= side_d;
      move_q  <= move_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign SC_JUG2_data_OutBUS = pos_q;
  assign SC_JUG2_side_OutLow = side_q;
  assign SC_JUG2_move_Out    = move_q;

endmodule

// File: tb/tb_sc_positionshifter_jug2.sv
// Table-driven bench for sc_positionshifter_jug2 (REPEAT_CYCLES=4).
// Each record is one clock: inputs plus hand-derived expected outputs.
module tb_sc_positionshifter_jug2;

  logic       clk = 1'b0;
  logic       rst;
  logic       left_n, right_n, load_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic       side_n, move;

  always #5 clk = ~clk;

  sc_positionshifter_jug2 #(
    .DATAWIDTH(8),
    .LANEWIDTH(4),
    .INIT_POS(8'b00000100),
    .REPEAT_CYCLES(4)
  ) dut (
    .SC_JUG2_CLOCK_50    (clk),
    .SC_JUG2_RESET_InHigh(rst),
    .SC_JUG2_left_InLow  (left_n),
    .SC_JUG2_right_InLow (right_n),
    .SC_JUG2_load_InLow  (load_n),
    .SC_JUG2_data_InBUS  (din),
    .SC_JUG2_data_OutBUS (dout),
    .SC_JUG2_side_OutLow (side_n),
    .SC_JUG2_move_Out    (move)
  );

  typedef struct {
    logic       rst;
    logic       l_n;
    logic       r_n;
    logic       ld_n;
    logic [7:0] din;
    logic [7:0] e_data;
    logic       e_side;
    logic       e_move;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       side;
    logic       move;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic l, input logic rr,
                     input logic ld, input logic [7:0] d,
                     input logic [7:0] ed, input logic es,
                     input logic em, input string nm);
    vec_t v;
    v.rst = r; v.l_n = l; v.r_n = rr; v.ld_n = ld; v.din = d;
    v.e_data = ed; v.e_side = es; v.e_move = em; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=empty required=entry");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (dout !== e.data) begin
      failures++;
      $display("FAIL %s data actual=%b required=%b",
               e.name, dout, e.data);
    end
    checks++;
    if (side_n !== e.side) begin
      failures++;
      $display("FAIL %s side actual=%b required=%b",
               e.name, side_n, e.side);
    end
    checks++;
    if (move !== e.move) begin
      failures++;
      $display("FAIL %s move actual=%b required=%b",
               e.name, move, e.move);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset held three clocks.
    for (int i = 0; i < 3; i++)
      add(1, 1, 1, 1, 8'h00, 8'h04, 1, 0, "reset");
    // Single left press, then release.
    add(0, 0, 1, 1, 8'h00, 8'h08, 0, 1, "left1");
    add(0, 1, 1, 1, 8'h00, 8'h08, 0, 0, "rel1");
    // Right held 16 clocks: steps at 1,5,9, saturated at 13.
    for (int i = 1; i <= 16; i++) begin
      if (i == 1)
        add(0, 1, 0, 1, 8'h00, 8'h04, 1, 1, "rhold");
      else if (i < 5)
        add(0, 1, 0, 1, 8'h00, 8'h04, 1, 0, "rhold");
      else if (i == 5)
        add(0, 1, 0, 1, 8'h00, 8'h02, 1, 1, "rhold");
      else if (i < 9)
        add(0, 1, 0, 1, 8'h00, 8'h02, 1, 0, "rhold");
      else if (i == 9)
        add(0, 1, 0, 1, 8'h00, 8'h01, 0, 1, "rhold");
      else
        add(0, 1, 0, 1, 8'h00, 8'h01, 0, 0, "rsat");
    end
    add(0, 1, 1, 1, 8'h00, 8'h01, 0, 0, "rel2");
    // Both buttons pressed: no request.
    for (int i = 0; i < 6; i++)
      add(0, 0, 0, 1, 8'h00, 8'h01, 0, 0, "both");
    add(0, 1, 1, 1, 8'h00, 8'h01, 0, 0, "rel3");
    // Loads: invalid patterns ignored, valid accepted.
    add(0, 1, 1, 0, 8'h06, 8'h01, 0, 0, "ld_twohot");
    add(0, 1, 1, 0, 8'h10, 8'h01, 0, 0, "ld_outlane");
    add(0, 1, 1, 0, 8'h00, 8'h01, 0, 0, "ld_zero");
    add(0, 1, 1, 0, 8'h02, 8'h02, 1, 1, "ld_ok");
    add(0, 1, 1, 0, 8'h02, 8'h02, 1, 0, "ld_same");
    add(0, 0, 1, 0, 8'h01, 8'h01, 0, 1, "ld_vs_left");
    // Left still held after load: fresh press from IDLE.
    add(0, 0, 1, 1, 8'h00, 8'h02, 1, 1, "left_after_ld");
    add(0, 0, 1, 1, 8'h00, 8'h02, 1, 0, "lwait");
    add(0, 0, 1, 1, 8'h00, 8'h02, 1, 0, "lwait");
    // Reset in WAIT, then held button steps immediately.
    add(1, 0, 1, 1, 8'h00, 8'h04, 1, 0, "rst_wait");
    add(0, 0, 1, 1, 8'h00, 8'h08, 0, 1, "post_rst");
    // Direction change: drop to IDLE, step next edge.
    add(0, 1, 0, 1, 8'h00, 8'h08, 0, 0, "dirchg");
    add(0, 1, 0, 1, 8'h00, 8'h04, 1, 1, "dir_new");
    add(0, 1, 1, 1, 8'h00, 8'h04, 1, 0, "rel4");

    rst = 1'b1; left_n = 1'b1; right_n = 1'b1;
    load_n = 1'b1; din = 8'h00;

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst;
      left_n = vecs[k].l_n;
      right_n = vecs[k].r_n;
      load_n = vecs[k].ld_n;
      din = vecs[k].din;
      e.data = vecs[k].e_data;
      e.side = vecs[k].e_side;
      e.move = vecs[k].e_move;
      e.name = vecs[k].name;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
    end

    // Hand sequence: move pulse lasts exactly one clock on a held press.
    @(negedge clk);
    left_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (move !== 1'b1 || dout !== 8'h08) begin
      failures++;
      $display("FAIL seq_pulse actual=%b/%b required=1/00001000",
               move, dout);
    end
    @(posedge clk); #1;
    checks++;
    if (move !== 1'b0) begin
      failures++;
      $display("FAIL seq_pulse_end actual=%b required=0", move);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
